// File: rtl/cube_pkg.sv
// ---------------------------------------------------------------------------
// cube_pkg
// Shared constants, FSM state encoding and a degree-wrap helper for the cube
// vertex rotation engine (cube_vertex_rotator and its rot_scale_mac datapath).
// ---------------------------------------------------------------------------
package cube_pkg;

  localparam int ANG_FULL  = 360;  // degrees per revolution
  localparam int ANG_QTR   = 90;   // cos(a) = sin(a + 90)
  localparam int SCALE_MUL = 655;  // 655 / 2^16 ~= 1/100
  localparam int SCALE_SH  = 16;
  localparam int NVERT     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD_SIN,
    ST_LD_COS,
    ST_ROT_X,
    ST_ROT_Y,
    ST_ROT_Z,
    ST_EMIT,
    ST_DONE
  } state_e;

  // Fold an angle below 2*360 into 0..359 with a single conditional subtract.
  function automatic logic [9:0] wrap_deg(input logic [9:0] a);
    return (a >= 10'(ANG_FULL)) ? a - 10'(ANG_FULL) : a;
  endfunction

endpackage

// File: rtl/rot_scale_mac.sv
// ---------------------------------------------------------------------------
// rot_scale_mac
// Shared multiplier plus four product registers p0..p3 used for every axis
// rotation. Each issue cycle stores mul_a * mul_b into p[sel]. The two results
// are formed combinationally from the held products:
//   res0 = scale(p0 -/+ p1), res1 = scale(p2 -/+ p3)
// where scale() divides by ~100 with rounding and saturates to COORD_W.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   issue, sel      write strobe and target product register
//   mul_a, mul_b    signed coordinate and signed sin/cos*100 operand
//   sub0, sub1      1 = subtract the second product of the pair
//   res0, res1      scaled, saturated rotated coordinates
// ---------------------------------------------------------------------------
module rot_scale_mac
  import cube_pkg::*;
#(
  parameter int COORD_W = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue,
  input  logic [1:0]                sel,
  input  logic signed [COORD_W-1:0] mul_a,
  input  logic signed [7:0]         mul_b,
  input  logic                      sub0,
  input  logic                      sub1,
  output logic signed [COORD_W-1:0] res0,
  output logic signed [COORD_W-1:0] res1
);

  localparam int PW = COORD_W + 8;   // product width
  localparam int SW = COORD_W + 9;   // sum of two products
  localparam logic signed [31:0] Q_MAX = (32'sd1 <<< (COORD_W - 1)) - 32'sd1;
  localparam logic signed [31:0] Q_MIN = -(32'sd1 <<< (COORD_W - 1));

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] p_q [4];
  logic signed [SW-1:0] sum0;
  logic signed [SW-1:0] sum1;

  assign a_ext = PW'(mul_a);
  assign b_ext = PW'(mul_b);
  assign prod  = a_ext * b_ext;

  for (genvar gi = 0; gi < 4; gi++) begin : g_prod
    logic signed [PW-1:0] p_d;

    always_comb begin
      p_d = p_q[gi];
      if (issue && (sel == 2'(gi))) begin
        p_d = prod;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        p_q[gi] <= '0;
      end else begin
        p_q[gi] <= p_d;
      end
    end
  end

  assign sum0 = sub0 ? (SW'(p_q[0]) - SW'(p_q[1])) : (SW'(p_q[0]) + SW'(p_q[1]));
  assign sum1 = sub1 ? (SW'(p_q[2]) - SW'(p_q[3])) : (SW'(p_q[2]) + SW'(p_q[3]));

  // Rounded divide by 100: (s*655 + 2^15) >>> 16 floors, then clamp.
  function automatic logic signed [COORD_W-1:0] scale_sat(input logic signed [SW-1:0] s);
    logic signed [31:0] t;
    logic signed [31:0] q;
    t = 32'(s) * 32'(SCALE_MUL) + 32'sd32768;
    q = t >>> SCALE_SH;
    if (q > Q_MAX) begin
      return Q_MAX[COORD_W-1:0];
    end else if (q < Q_MIN) begin
      return Q_MIN[COORD_W-1:0];
    end
    return q[COORD_W-1:0];
  endfunction

  assign res0 = scale_sat(sum0);
  assign res1 = scale_sat(sum1);

endmodule

// File: rtl/cube_vertex_rotator.sv
// ---------------------------------------------------------------------------
// cube_vertex_rotator
// On start, fetches sin/cos of the X/Y/Z angles from an external
// combinational sine LUT, then rotates the 8 cube corners X->Y->Z with one
// shared multiplier and streams each vertex out on a valid/ready port.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, angle_x/y/z       run request (IDLE only) and angles 0..719 deg
//   busy, done               not-IDLE flag, 1-cycle end-of-run pulse
//   lut_deg_x/y/z            LUT addresses 0..359 (0 when not loading)
//   lut_val_x/y/z            signed sin*100 returned in the same cycle
//   out_valid/out_ready      vertex handshake, data held while stalled
//   out_idx, out_x/y/z       vertex index and rotated coordinates
// ---------------------------------------------------------------------------
module cube_vertex_rotator
  import cube_pkg::*;
#(
  parameter int HALF    = 40,
  parameter int COORD_W = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [9:0]                angle_x,
  input  logic [9:0]                angle_y,
  input  logic [9:0]                angle_z,
  output logic                      busy,
  output logic                      done,
  output logic [9:0]                lut_deg_x,
  output logic [9:0]                lut_deg_y,
  output logic [9:0]                lut_deg_z,
  input  logic signed [7:0]         lut_val_x,
  input  logic signed [7:0]         lut_val_y,
  input  logic signed [7:0]         lut_val_z,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2:0]                out_idx,
  output logic signed [COORD_W-1:0] out_x,
  output logic signed [COORD_W-1:0] out_y,
  output logic signed [COORD_W-1:0] out_z
);

  localparam logic signed [COORD_W-1:0] POS_C = COORD_W'(HALF);
  localparam logic signed [COORD_W-1:0] NEG_C = COORD_W'(-HALF);

  state_e                     state_q, state_d;
  logic [2:0]                 step_q, step_d;
  logic [2:0]                 idx_q, idx_d;
  logic signed [COORD_W-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;

  logic [9:0]                 ang_in  [3];
  logic signed [7:0]          lut_val [3];
  logic [9:0]                 lut_deg [3];
  logic signed [7:0]          sin_v   [3];
  logic signed [7:0]          cos_v   [3];

  logic                       issue;
  logic                       sub0, sub1;
  logic signed [COORD_W-1:0]  mul_a;
  logic signed [7:0]          mul_b;
  logic signed [COORD_W-1:0]  res0, res1;
  logic [2:0]                 idx_inc;

  assign ang_in[0]  = angle_x;
  assign ang_in[1]  = angle_y;
  assign ang_in[2]  = angle_z;
  assign lut_val[0] = lut_val_x;
  assign lut_val[1] = lut_val_y;
  assign lut_val[2] = lut_val_z;

  // Per-axis angle, sine and cosine registers.
  for (genvar gi = 0; gi < 3; gi++) begin : g_axis
    logic [9:0]        ang_q, ang_d;
    logic signed [7:0] s_q, s_d, c_q, c_d;

    always_comb begin
      ang_d = ang_q;
      s_d   = s_q;
      c_d   = c_q;
      if (state_q == ST_IDLE && start) begin
        ang_d = wrap_deg(ang_in[gi]);
      end
      if (state_q == ST_LD_SIN) begin
        s_d = lut_val[gi];
      end
      if (state_q == ST_LD_COS) begin
        c_d = lut_val[gi];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        ang_q <= '0;
        s_q   <= '0;
        c_q   <= '0;
      end else begin
        ang_q <= ang_d;
        s_q   <= s_d;
        c_q   <= c_d;
      end
    end

    assign lut_deg[gi] = (state_q == ST_LD_SIN) ? ang_q :
                         (state_q == ST_LD_COS) ? wrap_deg(ang_q + 10'(ANG_QTR)) :
                         10'd0;
    assign sin_v[gi] = s_q;
    assign cos_v[gi] = c_q;
  end

  assign lut_deg_x = lut_deg[0];
  assign lut_deg_y = lut_deg[1];
  assign lut_deg_z = lut_deg[2];

  // Operand schedule: each axis issues four products; the pair ordering
  // matches rot_scale_mac's (p0 -/+ p1, p2 -/+ p3) combine.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    sub0  = 1'b0;
    sub1  = 1'b0;
    issue = 1'b0;
    case (state_q)
      ST_ROT_X: begin  // y' = y*c - z*s ; z' = y*s + z*c
        sub0 = 1'b1;
        case (step_q[1:0])
          2'd0:    begin mul_a = y_q; mul_b = cos_v[0]; end
          2'd1:    begin mul_a = z_q; mul_b = sin_v[0]; end
          2'd2:    begin mul_a = y_q; mul_b = sin_v[0]; end
          default: begin mul_a = z_q; mul_b = cos_v[0]; end
        endcase
        issue = (step_q != 3'd4);
      end
      ST_ROT_Y: begin  // x' = x*c + z*s ; z' = z*c - x*s
        sub1 = 1'b1;
        case (step_q[1:0])
          2'd0:    begin mul_a = x_q; mul_b = cos_v[1]; end
          2'd1:    begin mul_a = z_q; mul_b = sin_v[1]; end
          2'd2:    begin mul_a = z_q; mul_b = cos_v[1]; end
          default: begin mul_a = x_q; mul_b = sin_v[1]; end
        endcase
        issue = (step_q != 3'd4);
      end
      ST_ROT_Z: begin  // x' = x*c - y*s ; y' = x*s + y*c
        sub0 = 1'b1;
        case (step_q[1:0])
          2'd0:    begin mul_a = x_q; mul_b = cos_v[2]; end
          2'd1:    begin mul_a = y_q; mul_b = sin_v[2]; end
          2'd2:    begin mul_a = x_q; mul_b = sin_v[2]; end
          default: begin mul_a = y_q; mul_b = cos_v[2]; end
        endcase
        issue = (step_q != 3'd4);
      end
      default: ;
    endcase
  end

  rot_scale_mac #(
    .COORD_W (COORD_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .issue (issue),
    .sel   (step_q[1:0]),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .sub0  (sub0),
    .sub1  (sub1),
    .res0  (res0),
    .res1  (res1)
  );

  assign idx_inc = idx_q + 3'd1;

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LD_SIN;
          idx_d   = 3'd0;
          step_d  = 3'd0;
        end
      end
      ST_LD_SIN: state_d = ST_LD_COS;
      ST_LD_COS: begin
        // Corner coordinates come straight from the index bits.
        x_d     = idx_q[2] ? POS_C : NEG_C;
        y_d     = idx_q[1] ? POS_C : NEG_C;
        z_d     = idx_q[0] ? POS_C : NEG_C;
        step_d  = 3'd0;
        state_d = ST_ROT_X;
      end
      ST_ROT_X, ST_ROT_Y, ST_ROT_Z: begin
        if (step_q == 3'd4) begin
          step_d = 3'd0;
          case (state_q)
            ST_ROT_X: begin y_d = res0; z_d = res1; state_d = ST_ROT_Y; end
            ST_ROT_Y: begin x_d = res0; z_d = res1; state_d = ST_ROT_Z; end
            default:  begin x_d = res0; y_d = res1; state_d = ST_EMIT;  end
          endcase
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (idx_q == 3'(NVERT - 1)) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_inc;
            x_d     = idx_inc[2] ? POS_C : NEG_C;
            y_d     = idx_inc[1] ? POS_C : NEG_C;
            z_d     = idx_inc[0] ? POS_C : NEG_C;
            step_d  = 3'd0;
            state_d = ST_ROT_X;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign out_valid = (state_q == ST_EMIT);
  assign out_idx   = idx_q;
  assign out_x     = x_q;
  assign out_y     = y_q;
  assign out_z     = z_q;

endmodule

// File: tb/tb_cube_vertex_rotator.sv
// ---------------------------------------------------------------------------
// tb_cube_vertex_rotator
// Scoreboard bench: each accepted start pushes the 8 expected vertices,
// computed from an ideal sine table with plain integer arithmetic; a monitor
// pops and compares on every out_valid/out_ready handshake and also checks
// that stalled outputs hold and that done follows the last vertex.
// ---------------------------------------------------------------------------
module tb_cube_vertex_rotator;

  localparam int CW   = 10;
  localparam int HALF = 40;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [9:0]           angle_x, angle_y, angle_z;
  logic                 busy, done;
  logic [9:0]           lut_deg_x, lut_deg_y, lut_deg_z;
  logic signed [7:0]    lut_val_x, lut_val_y, lut_val_z;
  logic                 out_valid, out_ready;
  logic [2:0]           out_idx;
  logic signed [CW-1:0] out_x, out_y, out_z;

  cube_vertex_rotator #(.HALF(HALF), .COORD_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .angle_x   (angle_x),
    .angle_y   (angle_y),
    .angle_z   (angle_z),
    .busy      (busy),
    .done      (done),
    .lut_deg_x (lut_deg_x),
    .lut_deg_y (lut_deg_y),
    .lut_deg_z (lut_deg_z),
    .lut_val_x (lut_val_x),
    .lut_val_y (lut_val_y),
    .lut_val_z (lut_val_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_z     (out_z)
  );

  always #5 clk = ~clk;

  // Ideal LUT: round(100*sin(d)).
  logic signed [7:0] sin_tab [0:359];
  assign lut_val_x = (lut_deg_x < 10'd360) ? sin_tab[lut_deg_x] : 8'sd0;
  assign lut_val_y = (lut_deg_y < 10'd360) ? sin_tab[lut_deg_y] : 8'sd0;
  assign lut_val_z = (lut_deg_z < 10'd360) ? sin_tab[lut_deg_z] : 8'sd0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int idx;
    int x;
    int y;
    int z;
  } vtx_t;

  vtx_t sb[$];
  vtx_t got [8];
  vtx_t ref2 [8];
  vtx_t held;
  bit   held_v = 1'b0;
  bit   prev_valid = 1'b0;
  bit   rand_ready = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   done_count = 0;
  int   run_base = 0;
  int   acc_cyc = 0;
  int   first_valid_cyc = -1;
  int   done_cyc = -1;

  task automatic check(input bit ok, input string name, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  // Divide by 100 as 655/65536 with +0.5 rounding, floor toward -inf, clamp.
  function automatic int scale100(input int sum);
    longint t;
    longint q;
    t = longint'(sum) * 655 + 32768;
    if (t >= 0) q = t / 65536;
    else q = -((-t + 65535) / 65536);
    if (q > 511) q = 511;
    if (q < -512) q = -512;
    return int'(q);
  endfunction

  function automatic void push_model(input int ax, input int ay, input int az);
    int a [3];
    int s [3];
    int c [3];
    int x, y, z, nx, ny, nz;
    vtx_t e;
    a[0] = ax; a[1] = ay; a[2] = az;
    for (int k = 0; k < 3; k++) begin
      s[k] = int'(sin_tab[a[k] % 360]);
      c[k] = int'(sin_tab[(a[k] + 90) % 360]);
    end
    for (int v = 0; v < 8; v++) begin
      x = ((v / 4) % 2 == 1) ? HALF : -HALF;
      y = ((v / 2) % 2 == 1) ? HALF : -HALF;
      z = (v % 2 == 1) ? HALF : -HALF;
      ny = scale100(y * c[0] - z * s[0]);
      nz = scale100(y * s[0] + z * c[0]);
      y = ny; z = nz;
      nx = scale100(x * c[1] + z * s[1]);
      nz = scale100(z * c[1] - x * s[1]);
      x = nx; z = nz;
      nx = scale100(x * c[2] - y * s[2]);
      ny = scale100(x * s[2] + y * c[2]);
      x = nx; y = ny;
      e.idx = v; e.x = x; e.y = y; e.z = z;
      sb.push_back(e);
    end
  endfunction

  // Monitor: handshake compare, stall hold, done ordering.
  initial begin
    vtx_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v     = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (held_v) begin
          ok = out_valid && (int'(out_idx) == held.idx) && (int'(out_x) == held.x)
               && (int'(out_y) == held.y) && (int'(out_z) == held.z);
          check(ok, "stall_hold", $sformatf("got v=%0b idx=%0d (%0d,%0d,%0d) held idx=%0d (%0d,%0d,%0d)",
                out_valid, out_idx, out_x, out_y, out_z, held.idx, held.x, held.y, held.z));
        end
        if (out_valid && !prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        prev_valid = out_valid;
        if (out_valid && out_ready) begin
          held_v = 1'b0;
          if (sb.size() == 0) begin
            check(1'b0, "unexpected_output", $sformatf("got idx=%0d with empty scoreboard, required none", out_idx));
          end else begin
            e = sb.pop_front();
            ok = (int'(out_idx) == e.idx) && (int'(out_x) == e.x)
                 && (int'(out_y) == e.y) && (int'(out_z) == e.z);
            check(ok, "vertex", $sformatf("got idx=%0d (%0d,%0d,%0d) required idx=%0d (%0d,%0d,%0d)",
                  out_idx, out_x, out_y, out_z, e.idx, e.x, e.y, e.z));
            got[out_idx].idx = int'(out_idx);
            got[out_idx].x   = int'(out_x);
            got[out_idx].y   = int'(out_y);
            got[out_idx].z   = int'(out_z);
            $display("vertex idx=%0d out=(%0d,%0d,%0d) exp=(%0d,%0d,%0d) cyc=%0d",
                     out_idx, out_x, out_y, out_z, e.x, e.y, e.z, cyc);
          end
        end else if (out_valid) begin
          held_v   = 1'b1;
          held.idx = int'(out_idx);
          held.x   = int'(out_x);
          held.y   = int'(out_y);
          held.z   = int'(out_z);
        end else begin
          held_v = 1'b0;
        end
        if (done) begin
          check(sb.size() == 0, "done_after_last",
                $sformatf("got done with %0d vertices pending, required 0", sb.size()));
          done_count++;
          done_cyc = cyc;
        end
      end
    end
  end

  // Random backpressure driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Watchdog: bounded run.
  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic issue_start(input int ax, input int ay, input int az);
    angle_x = 10'(ax);
    angle_y = 10'(ay);
    angle_z = 10'(az);
    start   = 1'b1;
    @(posedge clk);
    #1;
    start           = 1'b0;
    acc_cyc         = cyc;
    first_valid_cyc = -1;
    run_base        = done_count;
    push_model(ax, ay, az);
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (done_count == run_base && n < limit) begin
      @(posedge clk);
      n++;
    end
    check(done_count == run_base + 1, "done_seen",
          $sformatf("got %0d done pulses, required 1 within %0d cycles", done_count - run_base, limit));
    repeat (3) @(posedge clk);
    #1;
    check(done_count == run_base + 1 && sb.size() == 0 && !busy, "run_end",
          $sformatf("got done=%0d pending=%0d busy=%0b, required 1,0,0", done_count - run_base, sb.size(), busy));
  endtask

  initial begin
    real r;
    bit  seen;
    for (int d = 0; d < 360; d++) begin
      r = 100.0 * $sin(real'(d) * 3.141592653589793 / 180.0);
      sin_tab[d] = 8'($rtoi((r >= 0.0) ? r + 0.5 : r - 0.5));
    end
    rst = 1'b1; start = 1'b0; angle_x = '0; angle_y = '0; angle_z = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(!busy && !done && !out_valid && out_idx == 3'd0 && out_x == 0 && out_y == 0 && out_z == 0
          && lut_deg_x == 10'd0 && lut_deg_y == 10'd0 && lut_deg_z == 10'd0, "reset_state",
          $sformatf("got busy=%0b done=%0b v=%0b idx=%0d (%0d,%0d,%0d) lut=%0d,%0d,%0d, required all 0",
                    busy, done, out_valid, out_idx, out_x, out_y, out_z, lut_deg_x, lut_deg_y, lut_deg_z));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: zero angles, identity, latency
    issue_start(0, 0, 0);
    wait_done(400);
    check(first_valid_cyc - acc_cyc == 17, "first_valid_latency",
          $sformatf("got %0d edges, required 17", first_valid_cyc - acc_cyc));
    check(done_cyc - acc_cyc == 130, "done_latency",
          $sformatf("got %0d edges (done in cycle %0d), required 130 (cycle 131)",
                    done_cyc - acc_cyc, done_cyc - acc_cyc + 1));
    check(got[0].x == -40 && got[0].y == -40 && got[0].z == -40 && got[7].x == 40 && got[7].y == 40
          && got[7].z == 40, "identity_corners",
          $sformatf("got idx0=(%0d,%0d,%0d) idx7=(%0d,%0d,%0d), required (-40,-40,-40) (40,40,40)",
                    got[0].x, got[0].y, got[0].z, got[7].x, got[7].y, got[7].z));

    // 2: X by 90
    issue_start(90, 0, 0);
    wait_done(400);
    check(got[0].x == -40 && got[0].y == 40 && got[0].z == -40 && got[7].x == 40 && got[7].y == -40
          && got[7].z == 40, "x90_corners",
          $sformatf("got idx0=(%0d,%0d,%0d) idx7=(%0d,%0d,%0d), required (-40,40,-40) (40,-40,40)",
                    got[0].x, got[0].y, got[0].z, got[7].x, got[7].y, got[7].z));
    ref2 = got;

    // 3: X by 450 wraps to 90; LUT addresses during the load cycles
    issue_start(450, 0, 0);
    @(negedge clk);
    check(busy && lut_deg_x == 10'd90 && lut_deg_y == 10'd0 && lut_deg_z == 10'd0, "lut_sin_addr",
          $sformatf("got busy=%0b %0d,%0d,%0d, required 1 90,0,0", busy, lut_deg_x, lut_deg_y, lut_deg_z));
    @(negedge clk);
    check(lut_deg_x == 10'd180 && lut_deg_y == 10'd90 && lut_deg_z == 10'd90, "lut_cos_addr",
          $sformatf("got %0d,%0d,%0d, required 180,90,90", lut_deg_x, lut_deg_y, lut_deg_z));
    wait_done(400);
    seen = 1'b1;
    for (int v = 0; v < 8; v++) begin
      if (got[v].x != ref2[v].x || got[v].y != ref2[v].y || got[v].z != ref2[v].z) seen = 1'b0;
    end
    check(seen, "wrap_450_eq_90", $sformatf("got idx7=(%0d,%0d,%0d), required run-2 idx7=(%0d,%0d,%0d)",
          got[7].x, got[7].y, got[7].z, ref2[7].x, ref2[7].y, ref2[7].z));
    issue_start(0, 0, 180);
    wait_done(400);
    check(got[0].x == 40 && got[0].y == 40 && got[0].z == -40, "z180_corner",
          $sformatf("got idx0=(%0d,%0d,%0d), required (40,40,-40)", got[0].x, got[0].y, got[0].z));

    // 4: random angles with random backpressure
    rand_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      issue_start(int'($urandom_range(0, 719)), int'($urandom_range(0, 719)), int'($urandom_range(0, 719)));
      wait_done(3000);
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;

    // 5: start held high through the run, angles changing every cycle
    angle_x = 10'd30; angle_y = 10'd60; angle_z = 10'd120; start = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc; run_base = done_count;
    push_model(30, 60, 120);
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        angle_x = 10'($urandom_range(0, 719));
        angle_y = 10'($urandom_range(0, 719));
        angle_z = 10'($urandom_range(0, 719));
      end
    end
    check(seen, "held_start_done", "got no done within 400 cycles, required one");
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check(!busy, "start_in_done_ignored", $sformatf("got busy=%0b after done, required 0", busy));
    repeat (3) @(posedge clk);
    #1;
    check(done_count == run_base + 1 && sb.size() == 0, "single_run",
          $sformatf("got %0d done pulses, %0d pending, required 1,0", done_count - run_base, sb.size()));

    // 6: reset during ROT_Y of vertex 3 (edge accept+57)
    issue_start(45, 135, 270);
    repeat (56) @(posedge clk);
    #1;
    check(sb.size() == 5, "pre_reset_progress", $sformatf("got %0d pending, required 5", sb.size()));
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check(!busy && !out_valid && !done && out_idx == 3'd0 && out_x == 0 && out_y == 0 && out_z == 0
          && lut_deg_x == 10'd0, "mid_run_reset",
          $sformatf("got busy=%0b v=%0b done=%0b idx=%0d (%0d,%0d,%0d), required all 0",
                    busy, out_valid, done, out_idx, out_x, out_y, out_z));
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check(done_count == run_base && !busy, "no_done_after_reset",
          $sformatf("got %0d done pulses busy=%0b, required 0,0", done_count - run_base, busy));
    issue_start(int'($urandom_range(0, 719)), int'($urandom_range(0, 719)), int'($urandom_range(0, 719)));
    wait_done(400);
    check(first_valid_cyc - acc_cyc == 17, "post_reset_latency",
          $sformatf("got %0d edges, required 17", first_valid_cyc - acc_cyc));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
